// File: rtl/store_align_unit_pkg.sv
// rtl/store_align_unit_pkg.sv - shared ALU codes, enable levels, size masks and issue FSM states
package store_align_unit_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [5:0] ALU_ADD = 6'd4;
  localparam logic [5:0] ALU_SB  = 6'd30;
  localparam logic [5:0] ALU_SH  = 6'd31;
  localparam logic [5:0] ALU_SW  = 6'd32;
  localparam logic [5:0] ALU_SD  = 6'd38;

  // Right-aligned byte masks, truncated to the lane count by the user
  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic {
    ISSUE_LO = 1'b0,
    ISSUE_HI = 1'b1
  } issue_state_t;

endpackage

// File: rtl/store_align_unit_fifo.sv
// rtl/store_align_unit_fifo.sv - DEPTH-entry store FIFO with full/empty/count, async active-low reset
module store_align_unit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: the head is only observed while count is non-zero
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - buffered store byte-mask/lane aligner; STORE_MISALIGN_SPLIT_EN splits crossing stores
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_is_store,
  input  logic [5:0]                req_alucode,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W/8-1:0]       mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      misalign_err,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int ENT_W = ADDR_W + BYTES + DATA_W;

  logic [BYTES-1:0]    in_mask;
  logic                in_store;
  logic                accept;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENT_W-1:0]    head_data;
  logic [ADDR_W-1:0]   head_addr;
  logic [BYTES-1:0]    head_mask;
  logic [DATA_W-1:0]   head_wdata;
  logic [OFF_W-1:0]    head_off;
  logic [ADDR_W-1:0]   base_addr;
  logic [2*BYTES-1:0]  head_span;
  logic [2*DATA_W-1:0] head_dspan;
  logic                sel_hi;
  logic                issue_valid;

  always_comb begin
    in_mask  = '0;
    in_store = 1'b0;
    if (req_is_store == ENABLE) begin
      case (req_alucode)
        ALU_SB: begin in_mask = MASK_B[BYTES-1:0]; in_store = 1'b1; end
        ALU_SH: begin in_mask = MASK_H[BYTES-1:0]; in_store = 1'b1; end
        ALU_SW: begin in_mask = MASK_W[BYTES-1:0]; in_store = 1'b1; end
        ALU_SD: begin
          if (DATA_W == 64) begin
            in_mask  = MASK_D[BYTES-1:0];
            in_store = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = rst_n && !fifo_full;
  assign accept    = req_valid && req_ready;

`ifdef STORE_MISALIGN_SPLIT_EN
  assign push         = accept && in_store;
  assign misalign_err = 1'b0;
`else
  logic [2*BYTES-1:0] in_span;
  logic               in_cross;

  assign in_span      = {{BYTES{1'b0}}, in_mask} << req_addr[OFF_W-1:0];
  assign in_cross     = (in_span >> BYTES) != '0;
  // Crossing stores are consumed without being queued
  assign push         = accept && in_store && !in_cross;
  assign misalign_err = accept && in_store && in_cross;
`endif

  store_align_unit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({req_addr, in_mask, req_wdata}),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign {head_addr, head_mask, head_wdata} = head_data;
  assign head_off   = head_addr[OFF_W-1:0];
  assign base_addr  = {head_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign head_span  = {{BYTES{1'b0}}, head_mask} << head_off;
  assign head_dspan = {{DATA_W{1'b0}}, head_wdata} << {head_off, 3'b000};

`ifdef STORE_MISALIGN_SPLIT_EN
  issue_state_t state, state_nxt;
  logic         head_cross;

  assign head_cross = (head_span >> BYTES) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ISSUE_LO;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    sel_hi      = (state == ISSUE_HI);
    issue_valid = !fifo_empty || sel_hi;
    case (state)
      ISSUE_LO: begin
        if (!fifo_empty && mem_ready) begin
          if (head_cross) state_nxt = ISSUE_HI;
          else            pop       = 1'b1;
        end
      end
      ISSUE_HI: begin
        if (mem_ready) begin
          pop       = 1'b1;
          state_nxt = ISSUE_LO;
        end
      end
      default: state_nxt = ISSUE_LO;
    endcase
  end
`else
  always_comb begin
    sel_hi      = 1'b0;
    issue_valid = !fifo_empty;
    pop         = issue_valid && mem_ready;
  end
`endif

  // Beat fields are gated so the port idles at zero whenever no beat is offered
  always_comb begin
    mem_valid = issue_valid;
    mem_addr  = '0;
    mem_we    = '0;
    mem_wdata = '0;
    if (issue_valid) begin
      if (sel_hi) begin
        mem_addr  = base_addr + ADDR_W'(BYTES);
        mem_we    = head_span[2*BYTES-1:BYTES];
        mem_wdata = head_dspan[2*DATA_W-1:DATA_W];
      end else begin
        mem_addr  = base_addr;
        mem_we    = head_span[BYTES-1:0];
        mem_wdata = head_dspan[DATA_W-1:0];
      end
    end
  end

  assign busy = !fifo_empty || sel_hi;

endmodule

// File: tb/tb_store_align_unit.sv
// tb/tb_store_align_unit.sv - directed table-driven bench for store_align_unit (DATA_W=32, DEPTH=4)
module tb_store_align_unit;
  import store_align_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [5:0]  req_alucode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        misalign_err;
  logic        busy;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_store;
    logic [5:0]  alu;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        push;
    logic [31:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] exp_order[5];
  int          n_issued;
  bit          fifth_acc;

  store_align_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_alucode  (req_alucode),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .misalign_err (misalign_err),
    .busy         (busy),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [5:0] a, input logic [31:0] ad, input logic [31:0] d);
    req_is_store = s;
    req_alucode  = a;
    req_addr     = ad;
    req_wdata    = d;
    req_valid    = 1'b1;
  endtask

  task automatic accept_one();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
  endtask

  task automatic handshake_one();
    @(negedge clk);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    #1;
  endtask

  task automatic check_beat(input string name, input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    check({name, "_valid"}, mem_valid, 1);
    check({name, "_addr"}, mem_addr, a);
    check({name, "_we"}, mem_we, we);
    check({name, "_wdata"}, mem_wdata, d);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ready"}, req_ready, 0);
    check({name, "_mem_valid"}, mem_valid, 0);
    check({name, "_mem_addr"}, mem_addr, 0);
    check({name, "_mem_we"}, mem_we, 0);
    check({name, "_mem_wdata"}, mem_wdata, 0);
    check({name, "_err"}, misalign_err, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_count"}, count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{ENABLE,  ALU_SB,  32'h1003, 32'h000000AB, 1, 32'h1000, 4'b1000, 32'hAB000000};
    vecs[1] = '{ENABLE,  ALU_SB,  32'h1001, 32'h12345678, 1, 32'h1000, 4'b0010, 32'h34567800};
    vecs[2] = '{ENABLE,  ALU_SB,  32'h1000, 32'h12345678, 1, 32'h1000, 4'b0001, 32'h12345678};
    vecs[3] = '{ENABLE,  ALU_SH,  32'h2002, 32'h0000BEEF, 1, 32'h2000, 4'b1100, 32'hBEEF0000};
    vecs[4] = '{ENABLE,  ALU_SH,  32'h2000, 32'h0000CAFE, 1, 32'h2000, 4'b0011, 32'h0000CAFE};
    vecs[5] = '{ENABLE,  ALU_SH,  32'h1001, 32'h0000ABCD, 1, 32'h1000, 4'b0110, 32'h00ABCD00};
    vecs[6] = '{ENABLE,  ALU_SW,  32'h3000, 32'hDEADBEEF, 1, 32'h3000, 4'b1111, 32'hDEADBEEF};
    vecs[7] = '{ENABLE,  ALU_ADD, 32'h4000, 32'h55555555, 0, 32'h0,    4'b0000, 32'h0};
    vecs[8] = '{DISABLE, ALU_SW,  32'h4000, 32'h66666666, 0, 32'h0,    4'b0000, 32'h0};
    vecs[9] = '{ENABLE,  ALU_SD,  32'h5000, 32'h77777777, 0, 32'h0,    4'b0000, 32'h0};
    exp_order[0] = 32'h0;
    exp_order[1] = 32'h4;
    exp_order[2] = 32'h8;
    exp_order[3] = 32'hC;
    exp_order[4] = 32'h10;

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_is_store = 1'b0;
    req_alucode = '0;
    req_addr = '0;
    req_wdata = '0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", req_ready, 1);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].is_store, vecs[i].alu, vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("v%0d_err", i), misalign_err, 0);
      check($sformatf("v%0d_ready", i), req_ready, 1);
      accept_one();
      check($sformatf("v%0d_count", i), count, {2'b00, vecs[i].push});
      check($sformatf("v%0d_valid", i), mem_valid, vecs[i].push);
      check($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_we", i), mem_we, vecs[i].e_we);
      check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
      if (vecs[i].push) begin
        handshake_one();
        check($sformatf("v%0d_drained", i), count, 0);
        check($sformatf("v%0d_idle", i), busy, 0);
      end
    end

    // Word-crossing SW at 0x2002
    @(negedge clk);
    drive(ENABLE, ALU_SW, 32'h2002, 32'h11223344);
    #1;
`ifdef STORE_MISALIGN_SPLIT_EN
    check("cross_err", misalign_err, 0);
    accept_one();
    check_beat("cross_b0", 32'h2000, 4'b1100, 32'h33440000);
    check("cross_b0_busy", busy, 1);
    handshake_one();
    check_beat("cross_b1", 32'h2004, 4'b0011, 32'h00001122);
    check("cross_b1_count", count, 1);
    check("cross_b1_busy", busy, 1);
    @(posedge clk);
    #1;
    check_beat("cross_b1_hold", 32'h2004, 4'b0011, 32'h00001122);
    handshake_one();
    check("cross_done_count", count, 0);
    check("cross_done_busy", busy, 0);
    check("cross_done_valid", mem_valid, 0);
`else
    check("cross_err_pulse", misalign_err, 1);
    accept_one();
    check("cross_err_gone", misalign_err, 0);
    check("cross_valid", mem_valid, 0);
    check("cross_count", count, 0);
    check("cross_we", mem_we, 0);
`endif

    // Fill the FIFO with the memory stalled
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(ENABLE, ALU_SW, exp_order[i], 32'hA0 + i);
      accept_one();
    end
    check("full_ready", req_ready, 0);
    check("full_count", count, 4);
    check_beat("full_head", 32'h0, 4'b1111, 32'hA0);
    drive(ENABLE, ALU_SW, 32'h10, 32'hA4);
    repeat (2) @(posedge clk);
    #1;
    check_beat("full_hold", 32'h0, 4'b1111, 32'hA0);
    check("full_hold_count", count, 4);
    @(negedge clk);
    mem_ready = 1'b1;
    n_issued = 0;
    fifth_acc = 1'b0;
    for (int c = 0; c < 30 && n_issued < 5; c++) begin
      #1;
      if (mem_valid) begin
        check($sformatf("order_%0d", n_issued), mem_addr, exp_order[n_issued]);
        n_issued++;
      end
      if (req_valid && req_ready) fifth_acc = 1'b1;
      @(posedge clk);
      #1;
      if (fifth_acc) req_valid = 1'b0;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    check("order_issued", n_issued, 5);
    check("fifth_accepted", fifth_acc, 1);
    check("order_drained", count, 0);

    // Crossing SH at the top of the address space, then reset mid-operation
    @(negedge clk);
    drive(ENABLE, ALU_SH, 32'hFFFFFFFF, 32'h0000BEEF);
    #1;
`ifdef STORE_MISALIGN_SPLIT_EN
    accept_one();
    check_beat("wrap_b0", 32'hFFFFFFFC, 4'b1000, 32'hEF000000);
    handshake_one();
    check_beat("wrap_b1", 32'h00000000, 4'b0001, 32'h000000BE);
    check("wrap_b1_busy", busy, 1);
`else
    check("wrap_err_pulse", misalign_err, 1);
    accept_one();
    check("wrap_valid", mem_valid, 0);
    @(negedge clk);
    drive(ENABLE, ALU_SW, 32'h40, 32'h12345678);
    accept_one();
    check_beat("pre_reset", 32'h40, 4'b1111, 32'h12345678);
`endif
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_ready", req_ready, 1);
    check("post_reset_valid", mem_valid, 0);
    check("post_reset_count", count, 0);
    check("post_reset_busy", busy, 0);
    @(posedge clk);
    #1;
    check("post_reset_still_idle", mem_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
